// File: rtl/mips_regfile_sb_if.sv
// Decode/writeback-facing bundle of the scoreboarded MIPS register file.
// The master is the pipeline side; the slave is the register file.
interface mips_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, sb_addr;
  logic [DATA_W-1:0] rd_data1, rd_data2, wr_data;
  logic              rd_busy1, rd_busy2, wr_en, sb_set, waw_err;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt, waw_err
  );
  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt, waw_err
  );
endinterface

// File: rtl/mips_regfile_sb.sv
// 2R1W MIPS register file with per-register busy scoreboard, optional
// hardwired zero register and optional writeback-to-read forwarding.
module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic clk,
  input  logic rst_n,
  mips_regfile_sb_if.slave rf
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NPORT = 2;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy, busy_nxt;
  logic [ADDR_W:0]              cnt_nxt, busy_cnt;
  logic                         waw_err, wr_ok, waw_hit;

  assign wr_ok = rf.wr_en && !(ZERO_REG != 0 && rf.wr_addr == '0);

  // New producer wins over a same-cycle writeback to the same register.
  for (genvar r = 0; r < DEPTH; r++) begin : g_sb
    logic set, clr;
    assign set = rf.sb_set && (rf.sb_addr == ADDR_W'(r)) && !(ZERO_REG != 0 && r == 0);
    assign clr = rf.wr_en && (rf.wr_addr == ADDR_W'(r));
    assign busy_nxt[r] = set | (busy[r] & ~clr);
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
  end

  // A writeback in the same cycle retires the old producer, so no WAW.
  assign waw_hit = rf.sb_set && busy[rf.sb_addr] &&
                   !(rf.wr_en && rf.wr_addr == rf.sb_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      busy     <= '0;
      busy_cnt <= '0;
      waw_err  <= 1'b0;
    end else begin
      if (wr_ok) regs[rf.wr_addr] <= rf.wr_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (waw_hit) waw_err <= 1'b1;
    end
  end

  logic [NPORT-1:0][ADDR_W-1:0] ra;
  logic [NPORT-1:0][DATA_W-1:0] rdat;
  logic [NPORT-1:0]             rbusy;

  assign ra = {rf.rd_addr2, rf.rd_addr1};

  // Forwarding is gated by rst_n so reads stay zero while reset is held.
  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int p = 0; p < NPORT; p++) begin
      automatic logic zh  = (ZERO_REG != 0) && (ra[p] == '0);
      automatic logic byp = (BYPASS != 0) && rst_n && rf.wr_en &&
                            (rf.wr_addr == ra[p]) && !zh;
      rdat[p]  = regs[ra[p]];
      rbusy[p] = busy[ra[p]];
      if (byp) begin
        rdat[p] = rf.wr_data;
        if (!(rf.sb_set && rf.sb_addr == ra[p])) rbusy[p] = 1'b0;
      end
      if (zh) begin
        rdat[p]  = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign rf.rd_data1 = rdat[0];
  assign rf.rd_data2 = rdat[1];
  assign rf.rd_busy1 = rbusy[0];
  assign rf.rd_busy2 = rbusy[1];
  assign rf.busy_cnt = busy_cnt;
  assign rf.waw_err  = waw_err;
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Scoreboard bench: three configurations (ZERO_REG/BYPASS = 1/1, 1/0, 0/1)
// share one stimulus stream and are compared against an array-based model.
module tb_mips_regfile_sb;
  localparam int NC = 3;
  localparam logic [NC-1:0] ZRV = 3'b011;
  localparam logic [NC-1:0] BPV = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, sb_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_en = 1'b0, sb_set = 1'b0;

  logic [NC-1:0][31:0] o_d1, o_d2;
  logic [NC-1:0]       o_b1, o_b2, o_waw;
  logic [NC-1:0][5:0]  o_cnt;

  always #5 clk = ~clk;

  for (genvar c = 0; c < NC; c++) begin : g_dut
    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifc ();
    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(int'(ZRV[c])),
                      .BYPASS(int'(BPV[c]))) dut (.clk(clk), .rst_n(rst_n), .rf(ifc));
    assign ifc.rd_addr1 = rd_addr1;
    assign ifc.rd_addr2 = rd_addr2;
    assign ifc.wr_en    = wr_en;
    assign ifc.wr_addr  = wr_addr;
    assign ifc.wr_data  = wr_data;
    assign ifc.sb_set   = sb_set;
    assign ifc.sb_addr  = sb_addr;
    assign o_d1[c]  = ifc.rd_data1;
    assign o_d2[c]  = ifc.rd_data2;
    assign o_b1[c]  = ifc.rd_busy1;
    assign o_b2[c]  = ifc.rd_busy2;
    assign o_cnt[c] = ifc.busy_cnt;
    assign o_waw[c] = ifc.waw_err;
  end

  // Reference model: architectural register and busy arrays per config.
  logic [31:0] mreg  [NC][32];
  bit          mbusy [NC][32];
  bit          mwaw  [NC];

  typedef struct packed {
    logic [NC-1:0][31:0] d1, d2;
    logic [NC-1:0]       b1, b2, waw;
    logic [NC-1:0][5:0]  cnt;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  function automatic bit hard0(int c, logic [4:0] a);
    return ZRV[c] && a == 5'd0;
  endfunction

  function automatic logic [31:0] m_data(int c, logic [4:0] a);
    if (hard0(c, a)) return 32'd0;
    if (BPV[c] && rst_n && wr_en && wr_addr == a) return wr_data;
    return mreg[c][a];
  endfunction

  function automatic logic m_busy(int c, logic [4:0] a);
    if (hard0(c, a)) return 1'b0;
    if (BPV[c] && rst_n && wr_en && wr_addr == a && !(sb_set && sb_addr == a)) return 1'b0;
    return mbusy[c][a];
  endfunction

  function automatic logic [5:0] m_cnt(int c);
    int n = 0;
    for (int r = 0; r < 32; r++) if (mbusy[c][r]) n++;
    return 6'(n);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mwaw[c] = 1'b0;
      for (int r = 0; r < 32; r++) begin
        mreg[c][r]  = 32'd0;
        mbusy[c][r] = 1'b0;
      end
    end
  endtask

  task automatic model_clock();
    if (!rst_n) model_reset();
    else begin
      for (int c = 0; c < NC; c++) begin
        if (sb_set && !hard0(c, sb_addr) && mbusy[c][sb_addr] &&
            !(wr_en && wr_addr == sb_addr)) mwaw[c] = 1'b1;
        if (wr_en && !hard0(c, wr_addr)) mreg[c][wr_addr] = wr_data;
        if (wr_en) mbusy[c][wr_addr] = 1'b0;
        if (sb_set && !hard0(c, sb_addr)) mbusy[c][sb_addr] = 1'b1;
      end
    end
  endtask

  // Inputs are stable at this point (posedge+1); push expectation, then clock.
  task automatic step();
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      e.d1[c]  = m_data(c, rd_addr1);
      e.d2[c]  = m_data(c, rd_addr2);
      e.b1[c]  = m_busy(c, rd_addr1);
      e.b2[c]  = m_busy(c, rd_addr2);
      e.cnt[c] = m_cnt(c);
      e.waw[c] = mwaw[c];
    end
    q.push_back(e);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(logic [4:0] a1, logic [4:0] a2, logic we, logic [4:0] wa,
                       logic [31:0] wd, logic ss, logic [4:0] sa);
    rd_addr1 = a1; rd_addr2 = a2; wr_en = we; wr_addr = wa;
    wr_data = wd; sb_set = ss; sb_addr = sa;
    step();
  endtask

  task automatic chk(string name, int c, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d: got %h expected %h at %0t", name, c, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      automatic exp_t e = q.pop_front();
      for (int c = 0; c < NC; c++) begin
        chk("rd_data1", c, o_d1[c], e.d1[c]);
        chk("rd_data2", c, o_d2[c], e.d2[c]);
        chk("rd_busy1", c, 32'(o_b1[c]), 32'(e.b1[c]));
        chk("rd_busy2", c, 32'(o_b2[c]), 32'(e.b2[c]));
        chk("busy_cnt", c, 32'(o_cnt[c]), 32'(e.cnt[c]));
        chk("waw_err",  c, 32'(o_waw[c]), 32'(e.waw[c]));
      end
    end
  end

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
  endfunction

  initial begin
    model_reset();
    @(posedge clk); #1;
    drive(5'd0, 5'd1, 1'b1, 5'd2, 32'hFFFF_FFFF, 1'b1, 5'd2);
    rst_n = 1'b1;

    for (int a = 0; a < 32; a += 2) drive(5'(a), 5'(a + 1), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    drive(5'd1, 5'd2, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
    drive(5'd5, 5'd5, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0);
    drive(5'd0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    drive(5'd7, 5'd5, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0);
    drive(5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    drive(5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    drive(5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    drive(5'd3, 5'd3, 1'b1, 5'd3, 32'h99, 1'b0, 5'd0);
    drive(5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    drive(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    drive(5'd9, 5'd9, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b1, 5'd9);
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'h0000_0042, 1'b1, 5'd0);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    for (int a = 1; a < 32; a++) drive(5'(a), 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(a));
    drive(5'd31, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    // Asynchronous reset mid-cycle: expectations for this cycle are all zero.
    rst_n = 1'b0;
    model_reset();
    drive(5'd5, 5'd7, 1'b1, 5'd5, 32'h1111_2222, 1'b1, 5'd6);
    rst_n = 1'b1;
    drive(5'd4, 5'd5, 1'b1, 5'd4, 32'h4444_4444, 1'b0, 5'd0);
    drive(5'd4, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    for (int a = 0; a < 32; a++) drive(5'(a), 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(a));
    drive(5'd0, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else rst_n = 1'b1;
      drive(raddr(), raddr(), 1'($urandom_range(0, 1)), raddr(), $urandom(),
            1'($urandom_range(0, 1)), raddr());
    end
    rst_n = 1'b1;
    drive(5'd0, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- Parametrised successor to the MIPS register file.
- Provides two combinational read ports, one synchronous write port, an optional hardwired zero register and optional write-to-read bypass.
- Includes a per-register busy scoreboard: decode marks a destination pending, writeback clears it, so the hazard unit can stall on true dependencies.
- Sits between decode (read/issue) and writeback (write) in the 32-bit MIPS pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and scoreboard sets.
- BYPASS, 1, 1 = same-cycle writeback data and busy-clear are forwarded to the read ports.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data (combinational).
- rd_data2  out  DATA_W  read port 2 data (combinational).
- rd_busy1  out  1  register at rd_addr1 has a pending producer.
- rd_busy2  out  1  register at rd_addr2 has a pending producer.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- sb_set  in  1  issue: mark sb_addr busy.
- sb_addr  in  ADDR_W  destination of the issuing instruction.
- busy_cnt  out  ADDR_W+1  number of busy registers (registered).
- waw_err  out  1  sticky: sb_set hit an already-busy register.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All DEPTH registers are cleared to 0; all busy bits, busy_cnt and waw_err are cleared to 0.
  - While reset is held, rd_data* = 0, rd_busy* = 0, and bypass is inactive.
  - Deassertion takes effect at the next clk edge; no memory-file preload.
- Write:
  - On posedge with wr_en=1, reg[wr_addr] <= wr_data.
  - With ZERO_REG=1 and wr_addr=0 the write is dropped.
- Read (combinational, zero latency):
  - rd_dataN = reg[rd_addrN].
  - With ZERO_REG=1 and rd_addrN=0, rd_dataN = 0.
  - With BYPASS=1, wr_en=1, wr_addr==rd_addrN and the address valid (not the zero register), rd_dataN = wr_data.
  - With BYPASS=0, the new value is visible from the cycle after the edge.
- Scoreboard update (per register r, on each posedge):
  - set   = sb_set & (sb_addr==r)
  - clear = wr_en & (wr_addr==r)
  - set & clear: busy stays/becomes 1 (new producer wins).
  - set only: busy <= 1.
  - clear only: busy <= 0.
  - Register 0 is never set when ZERO_REG=1.
  - A writeback to a non-busy register is legal: data is written, busy stays 0.
- Busy outputs:
  - rd_busyN = busy[rd_addrN].
  - With BYPASS=1, rd_busyN is forced 0 when a same-cycle writeback matches rd_addrN and no same-cycle sb_set targets that address.
  - rd_busyN = 0 for address 0 when ZERO_REG=1.
- busy_cnt:
  - Registered population count of the busy bits after the update.
  - Range 0..DEPTH; it must reach DEPTH without wrap (hence width ADDR_W+1).
- waw_err:
  - Set on the posedge where sb_set=1, busy[sb_addr]=1 and there is no same-cycle clear of sb_addr.
  - Held until reset; it does not block the set.
- Reset mid-operation: all pending busy state is discarded; a writeback arriving after reset writes data normally and leaves busy at 0.

Test Plan:
- Reset then read all addresses -> every rd_data = 0, rd_busy = 0, busy_cnt = 0, waw_err = 0.
- Write 0xDEADBEEF to r5; next cycle read r5 on both ports -> 0xDEADBEEF on both. Write 0x1234 to r0 -> r0 still reads 0.
- Same-cycle write r7=0xA5A5A5A5 with rd_addr1=7, BYPASS=1 -> rd_data1 = 0xA5A5A5A5 in that cycle. With BYPASS=0 -> old value, then 0xA5A5A5A5 one cycle later.
- sb_set r3 -> rd_busy1(r3)=1 and busy_cnt=1. Later wr_en r3=0x99 -> busy clears and busy_cnt=0; rd_busy shows 0 in the writeback cycle when BYPASS=1.
- Simultaneous sb_set r9 and wr_en r9 (r9 busy) -> r9 data updated, busy stays 1, waw_err stays 0. A second sb_set r9 with no writeback -> waw_err=1, sticky until rst_n pulse.
- Set all 31 non-zero registers, then assert rst_n=0 asynchronously mid-cycle -> busy_cnt drops to 0 immediately and all data is 0. Set 32 registers with ZERO_REG=0 -> busy_cnt = 32.
